seven_seg_scan_decoder: RTL and testbench

Recovers hexadecimal digit values from the active-low seven-segment drive signals of a time-multiplexed display, which makes it the inverse of the hex-to-segment encoder used on the DE2 displays. It sits on the monitor side of the display path, for self-check and loopback of the display scanner. It debounces each multiplexed digit slot, decodes the segment pattern back to a nibble, and flags patterns it does not recognise. It publishes a per-digit value register and a frame-complete strobe.

---
 rtl/seven_seg_scan_decoder.sv | 131 +++++++++++++
 tb/tb_seven_seg_scan_decoder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_decoder.sv
// Recovers hex digits from active-low multiplexed seven-segment drive; captures after STABLE_CYCLES identical samples.
// Latency: input change before edge k updates outputs at edge k+STABLE_CYCLES; no backpressure (monitor only).
module seven_seg_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [6:0]            Seg_In,
  input  logic [DIGITS-1:0]     Digit_En,
  output logic [4*DIGITS-1:0]   Value_Out,
  output logic [DIGITS-1:0]     Digit_Valid,
  output logic                  Error_Out,
  output logic                  Frame_Done
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  state_t              state;
  logic [CW-1:0]       count;
  logic [6:0]          seg_q, seg_p;
  logic [DIGITS-1:0]   en_q, en_p;
  logic [DIGITS-1:0]   captured_mask;

  logic                changed;
  logic                one_hot;
  logic [IW-1:0]       sel;
  logic [3:0]          zeros;
  logic [DIGITS-1:0]   mask_set;
  logic                dec_legal, dec_blank;
  logic [3:0]          dec_nib;

  // Returns {legal, blank, nibble}.
  function automatic logic [5:0] decode(input logic [6:0] s);
    case (s)
      7'b0000001: decode = 6'b10_0000;
      7'b1001111: decode = 6'b10_0001;
      7'b0010010: decode = 6'b10_0010;
      7'b0000110: decode = 6'b10_0011;
      7'b1001100: decode = 6'b10_0100;
      7'b0100100: decode = 6'b10_0101;
      7'b0100000: decode = 6'b10_0110;
      7'b0001111: decode = 6'b10_0111;
      7'b0000000: decode = 6'b10_1000;
      7'b0000100: decode = 6'b10_1001;
      7'b0001000: decode = 6'b10_1010;
      7'b1100000: decode = 6'b10_1011;
      7'b0110001: decode = 6'b10_1100;
      7'b1000010: decode = 6'b10_1101;
      7'b0110000: decode = 6'b10_1110;
      7'b0111000: decode = 6'b10_1111;
      7'b1111111: decode = 6'b01_0000;
      default:    decode = 6'b00_0000;
    endcase
  endfunction

  always_comb begin
    changed = ({seg_q, en_q} != {seg_p, en_p});
    {dec_legal, dec_blank, dec_nib} = decode(seg_q);
    zeros = 4'd0;
    sel   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!en_q[i]) begin
        zeros = zeros + 4'd1;
        sel   = IW'(i);
      end
    end
    one_hot       = (zeros == 4'd1);
    mask_set      = captured_mask;
    mask_set[sel] = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= IDLE;
      count         <= '0;
      seg_q         <= '1;
      seg_p         <= '1;
      en_q          <= '1;
      en_p          <= '1;
      captured_mask <= '0;
      Value_Out     <= '0;
      Digit_Valid   <= '0;
      Error_Out     <= 1'b0;
      Frame_Done    <= 1'b0;
    end else begin
      seg_q      <= Seg_In;
      en_q       <= Digit_En;
      seg_p      <= seg_q;
      en_p       <= en_q;
      Error_Out  <= 1'b0;
      Frame_Done <= 1'b0;
      if (changed) begin
        state <= SETTLE;
        count <= CW'(1);
      end else if (state == SETTLE) begin
        if (count == CW'(STABLE_CYCLES - 1)) begin
          // Count saturates at STABLE_CYCLES; a malformed select abandons the settle.
          count <= CW'(STABLE_CYCLES);
          if (one_hot) begin
            state <= HELD;
            if (dec_legal) begin
              Value_Out[{sel, 2'b00} +: 4] <= dec_nib;
              Digit_Valid[sel]             <= 1'b1;
            end else if (dec_blank) begin
              Value_Out[{sel, 2'b00} +: 4] <= 4'h0;
              Digit_Valid[sel]             <= 1'b0;
            end else begin
              Digit_Valid[sel] <= 1'b0;
              Error_Out        <= 1'b1;
            end
            if (&mask_set) begin
              Frame_Done    <= 1'b1;
              captured_mask <= '0;
            end else begin
              captured_mask <= mask_set;
            end
          end else begin
            state <= IDLE;
          end
        end else begin
          count <= count + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed plus randomized bench for seven_seg_scan_decoder against a run-length reference model.
module tb_seven_seg_scan_decoder;
  localparam int D = 4;
  localparam int S = 4;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [6:0]    Seg_In;
  logic [D-1:0]  Digit_En;
  logic [4*D-1:0] Value_Out;
  logic [D-1:0]  Digit_Valid;
  logic          Error_Out;
  logic          Frame_Done;

  seven_seg_scan_decoder #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
    .Clock(Clock), .Reset(Reset), .Seg_In(Seg_In), .Digit_En(Digit_En),
    .Value_Out(Value_Out), .Digit_Valid(Digit_Valid),
    .Error_Out(Error_Out), .Frame_Done(Frame_Done)
  );

  always #5 Clock = ~Clock;

  logic [6:0] pat [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Reference state: a capture happens one edge after a run of S identical samples completes.
  logic [4*D-1:0] m_val;
  logic [D-1:0]   m_vld, m_mask, m_en;
  logic           m_err, m_fd;
  logic [6:0]     m_seg;
  int             run;
  int             passes, fails, total;
  int             err_seen, fd_seen;
  logic [4*D-1:0] snap_val;
  logic [D-1:0]   snap_vld;

  function automatic int lookup(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (pat[i] == s) return i;
    if (s == 7'h7F) return 16;
    return 17;
  endfunction

  task automatic model_edge();
    int zeros, idx, v;
    if (Reset) begin
      m_val = '0; m_vld = '0; m_mask = '0; m_err = 0; m_fd = 0;
      m_seg = 7'h7F; m_en = '1; run = 0;
    end else begin
      m_err = 0; m_fd = 0;
      if (run == S) begin
        zeros = 0; idx = 0;
        for (int i = 0; i < D; i++) if (!m_en[i]) begin zeros++; idx = i; end
        if (zeros == 1) begin
          v = lookup(m_seg);
          if (v < 16) begin
            m_val[idx*4 +: 4] = v[3:0]; m_vld[idx] = 1'b1;
          end else if (v == 16) begin
            m_val[idx*4 +: 4] = 4'h0; m_vld[idx] = 1'b0;
          end else begin
            m_vld[idx] = 1'b0; m_err = 1'b1;
          end
          m_mask[idx] = 1'b1;
          if (&m_mask) begin m_fd = 1'b1; m_mask = '0; end
        end
      end
      if ({Seg_In, Digit_En} != {m_seg, m_en}) begin
        m_seg = Seg_In; m_en = Digit_En; run = 1;
      end else if (run > 0 && run < 1000) begin
        run++;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge Clock);
    model_edge();
    #1;
    if (Error_Out) err_seen++;
    if (Frame_Done) fd_seen++;
    check("value", 32'(Value_Out), 32'(m_val));
    check("valid", 32'(Digit_Valid), 32'(m_vld));
    check("error", 32'(Error_Out), 32'(m_err));
    check("frame", 32'(Frame_Done), 32'(m_fd));
  endtask

  task automatic hold(input logic [6:0] seg, input logic [D-1:0] en, input int n);
    Seg_In = seg; Digit_En = en;
    repeat (n) cycle();
  endtask

  initial begin
    int r, dg, n;
    logic [D-1:0] en;
    logic [6:0] sg;
    passes = 0; fails = 0; total = 0; run = 0;
    Reset = 1'b1; Seg_In = 7'h7F; Digit_En = '1;
    cycle(); cycle();
    check("rst_value", 32'(Value_Out), 32'h0);
    check("rst_valid", 32'(Digit_Valid), 32'h0);
    Reset = 1'b0;

    // Single capture of digit 0 = 2, then static hold.
    err_seen = 0;
    hold(7'b0010010, 4'b1110, 4);
    check("t1_early", 32'(Digit_Valid), 32'h0);
    cycle();
    check("t1_nib", 32'(Value_Out[3:0]), 32'h2);
    check("t1_valid", 32'(Digit_Valid), 32'h1);
    hold(7'b0010010, 4'b1110, 6);
    check("t1_noerr", 32'(err_seen), 32'h0);

    // Full scan completes a frame.
    fd_seen = 0;
    hold(7'b1001111, 4'b1110, 6);
    hold(7'b0001000, 4'b1101, 6);
    hold(7'b0110001, 4'b1011, 6);
    hold(7'b0000000, 4'b0111, 6);
    check("scan_value", 32'(Value_Out), 32'h8CA1);
    check("scan_valid", 32'(Digit_Valid), 32'hF);
    check("scan_frames", 32'(fd_seen), 32'h1);

    // Illegal pattern on digit 1.
    err_seen = 0;
    hold(7'b1111110, 4'b1101, 8);
    check("ill_errs", 32'(err_seen), 32'h1);
    check("ill_nib", 32'(Value_Out[7:4]), 32'hA);
    check("ill_valid", 32'(Digit_Valid[1]), 32'h0);

    // Glitch during settle.
    hold(7'b0000001, 4'b1110, 2);
    hold(7'b0000000, 4'b1110, 2);
    hold(7'b0000001, 4'b1110, 6);
    check("glitch_nib", 32'(Value_Out[3:0]), 32'h0);
    check("glitch_valid", 32'(Digit_Valid[0]), 32'h1);

    // Two digits selected: nothing captured.
    snap_val = Value_Out; snap_vld = Digit_Valid; err_seen = 0; fd_seen = 0;
    hold(7'b0010010, 4'b1100, 10);
    check("twohot_val", 32'(Value_Out), 32'(snap_val));
    check("twohot_vld", 32'(Digit_Valid), 32'(snap_vld));
    check("twohot_pulses", 32'(err_seen + fd_seen), 32'h0);

    // Reset mid-settle, then restart.
    hold(7'b0000100, 4'b1011, 4);
    Reset = 1'b1;
    cycle();
    check("midrst_val", 32'(Value_Out), 32'h0);
    check("midrst_vld", 32'(Digit_Valid), 32'h0);
    Reset = 1'b0;
    hold(7'b0000100, 4'b1011, 4);
    check("rst_restart_early", 32'(Digit_Valid), 32'h0);
    cycle();
    check("rst_restart_nib", 32'(Value_Out[11:8]), 32'h9);

    // Randomized scan traffic.
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        Reset = 1'b1; cycle(); Reset = 1'b0;
      end else begin
        dg = $urandom_range(0, D - 1);
        en = '1; en[dg] = 1'b0;
        if (r == 1) en = D'($urandom);
        if (r < 14) sg = pat[$urandom_range(0, 15)];
        else if (r < 16) sg = 7'h7F;
        else sg = 7'($urandom);
        n = $urandom_range(1, 7);
        hold(sg, en, n);
      end
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
